// File: rtl/dnn_layer_engine.sv
// dnn_layer_engine: fully-connected DNN layer accelerator.
// A slave register port configures the layer. A single-outstanding master port
// fetches bias, weights and activations, and writes each output neuron back.
// Build option: define DNN_SAT_EN to saturate results to the DATA_W range.
// Without it, results wrap to their low DATA_W bits.
module dnn_layer_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [31:0]       master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  output logic              irq
);

  localparam int ACC_W = 2*DATA_W + 8;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [3:0] {IDLE, RD_B, WT_B, RD_W, WT_W, RD_A, WT_A, MAC, WR_O, FIN} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               bias_addr_q, w_addr_q, in_addr_q, out_addr_q;
  logic [LEN_W-1:0]          in_len_q, out_len_q;
  logic                      relu_q, irq_en_q, done_q, err_q;
  logic [LEN_W-1:0]          i_q, i_d, j_q, j_d;
  logic [31:0]               widx_q, widx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  w_q, w_d, a_q, a_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext;
  logic [LEN_W:0]            i_nxt, j_nxt;
  logic                      busy, start, unused_ok;

  // Shift out the fraction, narrow to DATA_W (saturate or wrap), then ReLU.
  function automatic logic [DATA_W-1:0] act_f(input logic signed [ACC_W-1:0] acc,
                                              input logic relu);
    logic signed [ACC_W-1:0] sh;
    logic [DATA_W-1:0]       r;
    sh = acc >>> FRAC_W;
`ifdef DNN_SAT_EN
    if (sh > SAT_MAX)      r = DATA_W'(SAT_MAX);
    else if (sh < SAT_MIN) r = DATA_W'(SAT_MIN);
    else                   r = DATA_W'(sh);
`else
    r = DATA_W'(sh);
`endif
    if (relu && r[DATA_W-1]) r = '0;
    return r;
  endfunction

  assign unused_ok         = slave_read;
  assign slave_waitrequest = 1'b0;
  assign busy              = (state_q != IDLE);
  assign start             = slave_write && (slave_address == 4'd0) && slave_writedata[0];
  assign irq               = done_q & irq_en_q;
  assign prod     = $signed({{DATA_W{w_q[DATA_W-1]}}, w_q}) * $signed({{DATA_W{a_q[DATA_W-1]}}, a_q});
  assign prod_ext = {{8{prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){master_readdata[DATA_W-1]}}, master_readdata};
  assign i_nxt    = {1'b0, i_q} + {{LEN_W{1'b0}}, 1'b1};
  assign j_nxt    = {1'b0, j_q} + {{LEN_W{1'b0}}, 1'b1};
  assign master_writedata = act_f(acc_q, relu_q);

  // Register readback, combinational on the word index.
  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0: slave_readdata = {29'd0, err_q, done_q, busy};
      4'd1: slave_readdata = bias_addr_q;
      4'd2: slave_readdata = w_addr_q;
      4'd3: slave_readdata = in_addr_q;
      4'd4: slave_readdata = out_addr_q;
      4'd5: slave_readdata = 32'(in_len_q);
      4'd6: slave_readdata = 32'(out_len_q);
      4'd7: slave_readdata = {31'd0, relu_q};
      4'd8: slave_readdata = {31'd0, irq_en_q};
      default: slave_readdata = 32'd0;
    endcase
  end

  // Layer sequencer: next state, datapath next values and master requests.
  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    j_d            = j_q;
    widx_d         = widx_q;
    acc_d          = acc_q;
    w_d            = w_q;
    a_d            = a_q;
    master_read    = 1'b0;
    master_write   = 1'b0;
    master_address = 32'd0;
    case (state_q)
      IDLE: if (start) begin
        i_d     = '0;
        j_d     = '0;
        widx_d  = 32'd0;
        state_d = (out_len_q == '0) ? FIN : RD_B;
      end
      RD_B: begin
        master_read    = 1'b1;
        master_address = bias_addr_q + (32'(i_q) << 2);
        if (!master_waitrequest) state_d = WT_B;
      end
      WT_B: if (master_readdatavalid) begin
        acc_d   = bias_ext <<< FRAC_W;
        j_d     = '0;
        state_d = (in_len_q != '0) ? RD_W : WR_O;
      end
      RD_W: begin
        master_read    = 1'b1;
        master_address = w_addr_q + (widx_q << 2);
        if (!master_waitrequest) state_d = WT_W;
      end
      WT_W: if (master_readdatavalid) begin
        w_d     = master_readdata;
        state_d = RD_A;
      end
      RD_A: begin
        master_read    = 1'b1;
        master_address = in_addr_q + (32'(j_q) << 2);
        if (!master_waitrequest) state_d = WT_A;
      end
      WT_A: if (master_readdatavalid) begin
        a_d     = master_readdata;
        state_d = MAC;
      end
      MAC: begin
        acc_d  = acc_q + prod_ext;
        widx_d = widx_q + 32'd1;
        if (j_nxt < {1'b0, in_len_q}) begin
          j_d     = j_nxt[LEN_W-1:0];
          state_d = RD_W;
        end else begin
          state_d = WR_O;
        end
      end
      WR_O: begin
        master_write   = 1'b1;
        master_address = out_addr_q + (32'(i_q) << 2);
        if (!master_waitrequest) begin
          if (i_nxt < {1'b0, out_len_q}) begin
            i_d     = i_nxt[LEN_W-1:0];
            state_d = RD_B;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any layer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      widx_q  <= 32'd0;
      acc_q   <= '0;
      w_q     <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      widx_q  <= widx_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      a_q     <= a_d;
    end
  end

  // Configuration and status registers; config writes while busy only flag ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_addr_q <= 32'd0;
      w_addr_q    <= 32'd0;
      in_addr_q   <= 32'd0;
      out_addr_q  <= 32'd0;
      in_len_q    <= '0;
      out_len_q   <= '0;
      relu_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (slave_write) begin
        if (slave_address == 4'd0) begin
          if (slave_writedata[1]) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
          end
          if (slave_writedata[0] && busy) err_q <= 1'b1;
        end else if (slave_address <= 4'd8) begin
          if (busy) begin
            err_q <= 1'b1;
          end else begin
            case (slave_address)
              4'd1: bias_addr_q <= slave_writedata;
              4'd2: w_addr_q    <= slave_writedata;
              4'd3: in_addr_q   <= slave_writedata;
              4'd4: out_addr_q  <= slave_writedata;
              4'd5: in_len_q    <= slave_writedata[LEN_W-1:0];
              4'd6: out_len_q   <= slave_writedata[LEN_W-1:0];
              4'd7: relu_q      <= slave_writedata[0];
              4'd8: irq_en_q    <= slave_writedata[0];
              default: ;
            endcase
          end
        end
      end
      if (state_q == FIN) done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dnn_layer_engine.sv
// Bench for dnn_layer_engine: table of directed layers plus reset, OUT_LEN=0/irq,
// stalled-bus and mid-layer reset sequences, against a simple memory model.
module tb_dnn_layer_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = 4'd0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'd0;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = 32'd0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        irq;

  always #5 clk = ~clk;

  dnn_layer_engine #(.DATA_W(32), .FRAC_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_write(master_write),
    .master_writedata(master_writedata), .irq(irq)
  );

  // Memory model: reads come from rdmem, writes are logged in order.
  logic [31:0] rdmem [0:255];
  logic [31:0] wlog_addr [0:63];
  logic [31:0] wlog_data [0:63];
  int wait_cfg = 0, stall_cnt = 0, rd_cnt = 0, wr_cnt = 0, proto_err = 0;
  logic prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;

  assign master_waitrequest = (master_read || master_write) && (stall_cnt < wait_cfg);

  always @(posedge clk) begin
    master_readdatavalid <= 1'b0;
    if (!rst) begin
      if (master_read && master_write) proto_err <= proto_err + 1;
      if (master_readdatavalid && (master_read || master_write)) proto_err <= proto_err + 1;
      if (prev_stall && (master_address != prev_addr || master_writedata != prev_wdata ||
                         master_read != prev_rd || master_write != prev_wr))
        proto_err <= proto_err + 1;
    end
    prev_stall <= master_waitrequest;
    prev_addr  <= master_address;
    prev_wdata <= master_writedata;
    prev_rd    <= master_read;
    prev_wr    <= master_write;
    if (master_read || master_write) begin
      if (master_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        if (master_read) begin
          rd_cnt               <= rd_cnt + 1;
          master_readdatavalid <= 1'b1;
          master_readdata      <= rdmem[master_address[9:2]];
        end
        if (master_write) begin
          wlog_addr[wr_cnt[5:0]] <= master_address;
          wlog_data[wr_cnt[5:0]] <= master_writedata;
          wr_cnt                 <= wr_cnt + 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [15:0]      in_len;
    logic [15:0]      out_len;
    logic             relu;
    logic [1:0][31:0] bias;
    logic [3:0][31:0] w;
    logic [1:0][31:0] x;
    logic [1:0][31:0] exp_out;
    logic [7:0]       exp_rd;
    logic [7:0]       exp_wr;
  } vec_t;

  vec_t vecs [6];
  int chk = 0, pass = 0;

  function automatic vec_t mk(input logic [15:0] il, input logic [15:0] ol, input logic rl,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] x0, input logic [31:0] x1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [7:0] nr, input logic [7:0] nw);
    vec_t v;
    v.in_len = il; v.out_len = ol; v.relu = rl;
    v.bias[0] = b0; v.bias[1] = b1;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.x[0] = x0; v.x[1] = x1;
    v.exp_out[0] = e0; v.exp_out[1] = e1;
    v.exp_rd = nr; v.exp_wr = nw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(posedge clk);
    #1 slave_write = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    #1 d = slave_readdata;
    slave_read = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    logic [31:0] v;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      reg_read(4'd0, v);
      if (v[1]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic load_vec(input vec_t v);
    rdmem[0] = v.bias[0]; rdmem[1] = v.bias[1];
    for (int k = 0; k < 4; k++) rdmem[64+k] = v.w[k];
    rdmem[128] = v.x[0]; rdmem[129] = v.x[1];
    reg_write(4'd1, 32'h0000_0000);
    reg_write(4'd2, 32'h0000_0100);
    reg_write(4'd3, 32'h0000_0200);
    reg_write(4'd4, 32'h0000_0300);
    reg_write(4'd5, {16'd0, v.in_len});
    reg_write(4'd6, {16'd0, v.out_len});
    reg_write(4'd7, {31'd0, v.relu});
  endtask

  task automatic check_outputs(input string tag, input vec_t v, input int r0, input int w0);
    check({tag, "_reads"}, 32'(rd_cnt - r0), {24'd0, v.exp_rd});
    check({tag, "_writes"}, 32'(wr_cnt - w0), {24'd0, v.exp_wr});
    for (int k = 0; k < 2; k++) begin
      if (k < int'(v.out_len)) begin
        check($sformatf("%s_out%0d_addr", tag, k), wlog_addr[6'(w0 + k)], 32'h300 + 32'(4*k));
        check($sformatf("%s_out%0d_data", tag, k), wlog_data[6'(w0 + k)], v.exp_out[k]);
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    logic ok;
    int r0, w0;
    logic [31:0] sat_exp;
`ifdef DNN_SAT_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h0001_0000;
`endif
    //        il ol rl bias0         bias1         w0            w1            w2            w3            x0            x1            e0            e1           rd  wr
    vecs[0] = mk(2, 1, 0, 32'h0001_0000, 32'h0,        32'h0002_0000, 32'h0003_0000, 32'h0,        32'h0,        32'h0001_0000, 32'h0001_0000, 32'h0006_0000, 32'h0,       5,  1);
    vecs[1] = mk(2, 1, 1, 32'hFFF0_0000, 32'h0,        32'h0002_0000, 32'h0003_0000, 32'h0,        32'h0,        32'h0001_0000, 32'h0001_0000, 32'h0,         32'h0,       5,  1);
    vecs[2] = mk(2, 1, 0, 32'hFFF0_0000, 32'h0,        32'h0002_0000, 32'h0003_0000, 32'h0,        32'h0,        32'h0001_0000, 32'h0001_0000, 32'hFFF5_0000, 32'h0,       5,  1);
    vecs[3] = mk(1, 1, 0, 32'h0,         32'h0,        32'h7FFF_0000, 32'h0,        32'h0,        32'h0,        32'h7FFF_0000, 32'h0,         sat_exp,       32'h0,       3,  1);
    vecs[4] = mk(2, 2, 1, 32'h0,         32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0002_0000, 32'h0005_8000, 10, 2);
    vecs[5] = mk(0, 1, 0, 32'hFFFE_0000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,         32'hFFFE_0000, 32'h0,       1,  1);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_mrd_mwr", {30'd0, master_read, master_write}, 32'd0);
    check("rst_waitreq", {31'd0, slave_waitrequest}, 32'd0);
    for (int a = 0; a < 10; a++) begin
      reg_read(4'(a), v);
      check($sformatf("rst_reg%0d", a), v, 32'd0);
    end

    // Table of directed layers
    for (int n = 0; n < 6; n++) begin
      load_vec(vecs[n]);
      r0 = rd_cnt; w0 = wr_cnt;
      reg_write(4'd0, 32'd1);
      wait_done(2000, ok);
      check($sformatf("vec%0d_done", n), {31'd0, ok}, 32'd1);
      reg_read(4'd0, v);
      check($sformatf("vec%0d_ctrl", n), v, 32'h2);
      check_outputs($sformatf("vec%0d", n), vecs[n], r0, w0);
      reg_write(4'd0, 32'd2);
    end

    // OUT_LEN=0 start, then irq set and cleared
    reg_write(4'd6, 32'd0);
    reg_write(4'd8, 32'd1);
    r0 = rd_cnt; w0 = wr_cnt;
    slave_address = 4'd0;
    reg_write(4'd0, 32'd1);
    ok = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 if (slave_readdata[1]) ok = 1'b1;
    end
    check("ol0_done_2cyc", {31'd0, ok}, 32'd1);
    check("ol0_ctrl", slave_readdata, 32'h2);
    check("ol0_irq_set", {31'd0, irq}, 32'd1);
    check("ol0_no_master", 32'(rd_cnt - r0 + wr_cnt - w0), 32'd0);
    reg_write(4'd0, 32'd2);
    #1 check("ol0_irq_clr", {31'd0, irq}, 32'd0);
    reg_write(4'd8, 32'd0);

    // Stalled bus with config write and start while busy
    load_vec(vecs[0]);
    wait_cfg = 10;
    r0 = rd_cnt; w0 = wr_cnt;
    reg_write(4'd0, 32'd1);
    repeat (20) @(posedge clk);
    reg_write(4'd2, 32'h0000_0180);
    reg_write(4'd0, 32'd1);
    wait_done(3000, ok);
    check("stall_done", {31'd0, ok}, 32'd1);
    reg_read(4'd0, v);
    check("stall_ctrl_err", v, 32'h6);
    reg_read(4'd2, v);
    check("stall_waddr", v, 32'h0000_0100);
    check_outputs("stall", vecs[0], r0, w0);
    reg_write(4'd0, 32'd2);
    reg_read(4'd0, v);
    check("stall_err_clr", v, 32'h0);
    wait_cfg = 0;

    // Reset in WT_W; a restart first must leave DONE set
    load_vec(vecs[0]);
    reg_write(4'd8, 32'd1);
    reg_write(4'd0, 32'd1);
    wait_done(2000, ok);
    check("rst_seq_done", {31'd0, ok}, 32'd1);
    r0 = rd_cnt;
    reg_write(4'd0, 32'd1);
    reg_read(4'd0, v);
    check("restart_keeps_done", v, 32'h3);
    check("restart_irq", {31'd0, irq}, 32'd1);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rd_cnt - r0 >= 2) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    check("reach_wt_w", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_mrd", {31'd0, master_read}, 32'd0);
    check("rst_mid_mwr", {31'd0, master_write}, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int a = 0; a < 9; a++) begin
      reg_read(4'(a), v);
      check($sformatf("rst_mid_reg%0d", a), v, 32'd0);
    end
    r0 = rd_cnt; w0 = wr_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_no_access", 32'(rd_cnt - r0 + wr_cnt - w0), 32'd0);
    check("protocol_errors", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
